// File: rtl/multicycle_ctrl_if.sv
// Control bundle between the multi-cycle controller and the datapath.
// master = controller side, slave = datapath side.
interface multicycle_ctrl_if #(
  parameter int CW = 16
);
  logic [5:0]    opcode;
  logic [5:0]    funct;
  logic          zero;
  logic          mem_ready;
  logic          ir_write;
  logic          pc_write;
  logic [1:0]    pc_src;
  logic          reg_write;
  logic          reg_dst;
  logic          mem_to_reg;
  logic          mem_oe;
  logic          mem_we;
  logic          alu_src_b;
  logic [3:0]    alu_ctrl;
  logic [1:0]    err;
  logic [CW-1:0] retired;

  modport master (
    input  opcode, funct, zero, mem_ready,
    output ir_write, pc_write, pc_src,
    output reg_write, reg_dst, mem_to_reg,
    output mem_oe, mem_we, alu_src_b,
    output alu_ctrl, err, retired
  );

  modport slave (
    output opcode, funct, zero, mem_ready,
    input  ir_write, pc_write, pc_src,
    input  reg_write, reg_dst, mem_to_reg,
    input  mem_oe, mem_we, alu_src_b,
    input  alu_ctrl, err, retired
  );
endinterface

// File: rtl/multicycle_ctrl.sv
// Multi-cycle control FSM for the 8-bit MIPS-style core.
// Optional retire counter: define CTRL_RETIRE_CNT_EN.
module multicycle_ctrl #(
  parameter int MAX_WAIT = 15,
  parameter int CW       = 16
) (
  input logic               clk,
  input logic               reset,
  multicycle_ctrl_if.master bus
);

  typedef enum logic [3:0] {
    FETCH, DECODE, EXEC_R, R_WB,
    EXEC_I, I_WB, MEM_ADDR, MEM_RD,
    MEM_WB, MEM_WR, BRANCH, JUMP
  } state_e;

  localparam logic [7:0] WAIT_LAST =
    8'(MAX_WAIT - 1);

  state_e     state_q, state_d;
  logic [7:0] wait_q, wait_d;
  logic [1:0] err_q, err_d;
  logic [3:0] r_alu;
  logic       r_ok;
  logic       is_r, is_addi, is_mem;
  logic       is_beq, is_j;

  // R-type funct to ALU op; r_ok flags supported functs
  always_comb begin
    r_ok  = 1'b1;
    r_alu = 4'd0;
    case (bus.funct)
      6'h20:   r_alu = 4'd2;
      6'h22:   r_alu = 4'd6;
      6'h24:   r_alu = 4'd0;
      6'h25:   r_alu = 4'd1;
      6'h27:   r_alu = 4'd12;
      6'h2A:   r_alu = 4'd7;
      default: r_ok  = 1'b0;
    endcase
  end

  assign is_r    = (bus.opcode == 6'h00) & r_ok;
  assign is_addi = (bus.opcode == 6'h08);
  assign is_mem  = (bus.opcode == 6'h23) |
                   (bus.opcode == 6'h2B);
  assign is_beq  = (bus.opcode == 6'h04);
  assign is_j    = (bus.opcode == 6'h02);

  // next state, memory wait counter and fault capture
  always_comb begin
    state_d = state_q;
    wait_d  = wait_q;
    err_d   = 2'b00;
    unique case (state_q)
      FETCH:  state_d = DECODE;
      DECODE: begin
        unique case (1'b1)
          is_r:    state_d = EXEC_R;
          is_addi: state_d = EXEC_I;
          is_mem:  state_d = MEM_ADDR;
          is_beq:  state_d = BRANCH;
          is_j:    state_d = JUMP;
          default: begin
            state_d = FETCH;
            err_d   = 2'b01;
          end
        endcase
      end
      EXEC_R: state_d = R_WB;
      EXEC_I: state_d = I_WB;
      MEM_ADDR: begin
        wait_d  = '0;
        // opcode bit 3 separates sw (0x2B) from lw (0x23)
        state_d = bus.opcode[3] ? MEM_WR : MEM_RD;
      end
      MEM_RD, MEM_WR: begin
        if (bus.mem_ready) begin
          state_d = (state_q == MEM_RD) ?
                    MEM_WB : FETCH;
        end else if (wait_q == WAIT_LAST) begin
          state_d = FETCH;
          err_d   = 2'b10;
        end else begin
          wait_d = wait_q + 8'd1;
        end
      end
      R_WB, I_WB, MEM_WB,
      BRANCH, JUMP: state_d = FETCH;
      default:      state_d = FETCH;
    endcase
  end

  // state, wait counter and error registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= FETCH;
      wait_q  <= '0;
      err_q   <= 2'b00;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
      err_q   <= err_d;
    end
  end

  // Moore control decode, forced low while in reset
  always_comb begin
    bus.ir_write   = 1'b0;
    bus.pc_write   = 1'b0;
    bus.pc_src     = 2'b00;
    bus.reg_write  = 1'b0;
    bus.reg_dst    = 1'b0;
    bus.mem_to_reg = 1'b0;
    bus.mem_oe     = 1'b0;
    bus.mem_we     = 1'b0;
    bus.alu_src_b  = 1'b0;
    bus.alu_ctrl   = 4'd0;
    if (reset) begin
      unique case (state_q)
        FETCH: begin
          bus.ir_write = 1'b1;
          bus.pc_write = 1'b1;
        end
        EXEC_R: bus.alu_ctrl = r_alu;
        R_WB: begin
          bus.alu_ctrl  = r_alu;
          bus.reg_write = 1'b1;
          bus.reg_dst   = 1'b1;
        end
        EXEC_I, MEM_ADDR: begin
          bus.alu_src_b = 1'b1;
          bus.alu_ctrl  = 4'd2;
        end
        I_WB: begin
          bus.alu_src_b = 1'b1;
          bus.alu_ctrl  = 4'd2;
          bus.reg_write = 1'b1;
        end
        MEM_RD: begin
          bus.alu_src_b = 1'b1;
          bus.alu_ctrl  = 4'd2;
          bus.mem_oe    = 1'b1;
        end
        MEM_WB: begin
          bus.alu_src_b  = 1'b1;
          bus.alu_ctrl   = 4'd2;
          bus.mem_oe     = 1'b1;
          bus.reg_write  = 1'b1;
          bus.mem_to_reg = 1'b1;
        end
        MEM_WR: begin
          bus.alu_src_b = 1'b1;
          bus.alu_ctrl  = 4'd2;
          bus.mem_we    = 1'b1;
        end
        BRANCH: begin
          bus.alu_ctrl = 4'd6;
          bus.pc_src   = 2'b01;
          bus.pc_write = bus.zero;
        end
        JUMP: begin
          bus.pc_src   = 2'b10;
          bus.pc_write = 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign bus.err = err_q;

`ifdef CTRL_RETIRE_CNT_EN
  logic          retire;
  logic [CW-1:0] retired_q, retired_d;

  assign retire =
    (state_q inside {R_WB, I_WB, MEM_WB,
                     BRANCH, JUMP}) |
    ((state_q == MEM_WR) & bus.mem_ready);

  assign retired_d = retire ?
                     retired_q + CW'(1) : retired_q;

  // count instructions that completed normally
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) retired_q <= '0;
    else        retired_q <= retired_d;
  end

  assign bus.retired = retired_q;
`else
  assign bus.retired = {CW{1'b0}};
`endif

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Randomized self-checking bench for multicycle_ctrl.
// Expected per-instruction cycle sequences come from a table model.
module tb_multicycle_ctrl;
  localparam int MAX_WAIT = 15;
  localparam int CW       = 16;

  logic clk = 1'b0;
  logic reset;

  multicycle_ctrl_if #(.CW(CW)) bus ();

  multicycle_ctrl #(
    .MAX_WAIT(MAX_WAIT),
    .CW(CW)
  ) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;
  int pend_err = 0;
  int exp_ret  = 0;

  logic [5:0] rfn [6] = '{6'h20, 6'h22, 6'h24,
                          6'h25, 6'h27, 6'h2A};

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h t=%0t",
               tag, got, exp, $time);
    end
  endtask

  function automatic logic [13:0] mk(
    bit irw, bit pcw, logic [1:0] pcs, bit rw,
    bit rd, bit m2r, bit oe, bit we, bit sb,
    logic [3:0] alu);
    return {irw, pcw, pcs, rw, rd, m2r,
            oe, we, sb, alu};
  endfunction

  function automatic logic [13:0] obs();
    return {bus.ir_write, bus.pc_write, bus.pc_src,
            bus.reg_write, bus.reg_dst,
            bus.mem_to_reg, bus.mem_oe, bus.mem_we,
            bus.alu_src_b, bus.alu_ctrl};
  endfunction

  function automatic int alu_of(logic [5:0] fn);
    case (fn)
      6'h20:   return 2;
      6'h22:   return 6;
      6'h24:   return 0;
      6'h25:   return 1;
      6'h27:   return 12;
      6'h2A:   return 7;
      default: return -1;
    endcase
  endfunction

  function automatic logic [31:0] ret_exp();
`ifdef CTRL_RETIRE_CNT_EN
    return 32'(exp_ret % (1 << CW));
`else
    return 32'd0;
`endif
  endfunction

  // w = mem_ready-low cycles in the memory state;
  // cut >= 0 pulls reset low during that cycle index
  task automatic run_instr(input logic [5:0] op,
                           input logic [5:0] fn,
                           input logic z,
                           input int w,
                           input int cut);
    logic [13:0] q [$];
    int ms, a, err_next;
    bit ret;
    ms = -1;
    err_next = 0;
    ret = 1'b1;
    a = alu_of(fn);
    q.push_back(mk(1,1,2'd0,0,0,0,0,0,0,4'd0));
    q.push_back(14'd0);
    if (op == 6'h00 && a >= 0) begin
      q.push_back(mk(0,0,2'd0,0,0,0,0,0,0,4'(a)));
      q.push_back(mk(0,0,2'd0,1,1,0,0,0,0,4'(a)));
    end else if (op == 6'h08) begin
      q.push_back(mk(0,0,2'd0,0,0,0,0,0,1,4'd2));
      q.push_back(mk(0,0,2'd0,1,0,0,0,0,1,4'd2));
    end else if (op == 6'h23 || op == 6'h2B) begin
      q.push_back(mk(0,0,2'd0,0,0,0,0,0,1,4'd2));
      ms = q.size();
      for (int k = 0; k < MAX_WAIT && k <= w; k++)
        q.push_back(op == 6'h23 ?
          mk(0,0,2'd0,0,0,0,1,0,1,4'd2) :
          mk(0,0,2'd0,0,0,0,0,1,1,4'd2));
      if (w >= MAX_WAIT) begin
        err_next = 2;
        ret = 1'b0;
      end else if (op == 6'h23) begin
        q.push_back(mk(0,0,2'd0,1,0,1,1,0,1,4'd2));
      end
    end else if (op == 6'h04) begin
      q.push_back(mk(0,z,2'd1,0,0,0,0,0,0,4'd6));
    end else if (op == 6'h02) begin
      q.push_back(mk(0,1,2'd2,0,0,0,0,0,0,4'd0));
    end else begin
      err_next = 1;
      ret = 1'b0;
    end

    bus.opcode = op;
    bus.funct  = fn;
    bus.zero   = z;
    for (int i = 0; i < q.size(); i++) begin
      if (ms >= 0 && i >= ms)
        bus.mem_ready = ((i - ms) >= w);
      else
        bus.mem_ready = 1'($urandom);
      @(negedge clk);
      check($sformatf("ctrl op%0h c%0d", op, i),
            32'(obs()), 32'(q[i]));
      check($sformatf("err op%0h c%0d", op, i),
            32'(bus.err),
            (i == 0) ? 32'(pend_err) : 32'd0);
      if (i == 0)
        check("retired", 32'(bus.retired), ret_exp());
      if (i == cut) begin
        #1 reset = 1'b0;
        #1;
        check("rst_ctrl", 32'(obs()), 32'd0);
        check("rst_err", 32'(bus.err), 32'd0);
        check("rst_ret", 32'(bus.retired), 32'd0);
        @(posedge clk);
        #1 reset = 1'b1;
        pend_err = 0;
        exp_ret  = 0;
        return;
      end
      @(posedge clk);
      #1;
    end
    pend_err = err_next;
    if (ret) exp_ret++;
  endtask

  initial begin
    logic [5:0] op, fn;
    int sel, w;
    reset = 1'b0;
    bus.opcode    = 6'h00;
    bus.funct     = 6'h20;
    bus.zero      = 1'b1;
    bus.mem_ready = 1'b0;
    repeat (2) begin
      @(negedge clk);
      check("reset_ctrl", 32'(obs()), 32'd0);
      check("reset_err", 32'(bus.err), 32'd0);
      check("reset_ret", 32'(bus.retired), 32'd0);
    end
    @(posedge clk);
    #1 reset = 1'b1;

    foreach (rfn[k]) run_instr(6'h00, rfn[k], 1'b0, 0, -1);
    run_instr(6'h23, 6'h00, 1'b0, 3, -1);
    run_instr(6'h2B, 6'h00, 1'b0, 100, -1);
    run_instr(6'h04, 6'h00, 1'b1, 0, -1);
    run_instr(6'h04, 6'h00, 1'b0, 0, -1);
    run_instr(6'h02, 6'h00, 1'b0, 0, -1);
    run_instr(6'h3F, 6'h00, 1'b0, 0, -1);
    run_instr(6'h00, 6'h00, 1'b0, 0, -1);
    run_instr(6'h23, 6'h00, 1'b0, MAX_WAIT - 1, -1);
    run_instr(6'h23, 6'h00, 1'b0, MAX_WAIT, -1);
    run_instr(6'h2B, 6'h00, 1'b0, MAX_WAIT - 1, -1);
    run_instr(6'h08, 6'h11, 1'b0, 0, -1);
    run_instr(6'h2B, 6'h00, 1'b0, 100, 5);

    for (int n = 0; n < 200; n++) begin
      sel = $urandom_range(0, 7);
      case (sel)
        0:       op = 6'h00;
        1:       op = 6'h08;
        2:       op = 6'h23;
        3:       op = 6'h2B;
        4:       op = 6'h04;
        5:       op = 6'h02;
        default: op = 6'($urandom);
      endcase
      if ($urandom_range(0, 3) != 0)
        fn = rfn[$urandom_range(0, 5)];
      else
        fn = 6'($urandom);
      if ($urandom_range(0, 3) == 0)
        w = $urandom_range(MAX_WAIT - 2, MAX_WAIT + 2);
      else
        w = $urandom_range(0, 4);
      run_instr(op, fn, 1'($urandom), w,
                ($urandom_range(0, 49) == 0) ? 1 : -1);
    end
    run_instr(6'h02, 6'h00, 1'b0, 0, -1);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end
endmodule
